// File: rtl/program_loader.sv
// program_loader: writes a framed byte stream (length, payload, checksum) into instruction memory from address 0.
// Latency: each payload transfer is written one cycle later; done/error follow the checksum transfer by one cycle.
// Backpressure: in_ready is high only in LEN/DATA/CHECK; in_valid gaps stall the frame indefinitely.
module program_loader #(
  parameter int BITS        = 8,
  parameter int MEMORY_BITS = 8,
  parameter int MEMORY_SIZE = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [BITS-1:0]        in_data,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [MEMORY_BITS-1:0] mem_addr,
  output logic [BITS-1:0]        mem_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [MEMORY_BITS:0]   loaded_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t                 state_q;
  logic                   busy_q;
  logic                   mem_we_q;
  logic                   done_q;
  logic                   error_q;
  logic [MEMORY_BITS-1:0] addr_q;
  logic [MEMORY_BITS-1:0] mem_addr_q;
  logic [BITS-1:0]        mem_data_q;
  logic [BITS-1:0]        sum_q;
  logic [MEMORY_BITS:0]   len_q;
  logic [MEMORY_BITS:0]   count_q;

  logic                   xfer;
  logic [MEMORY_BITS:0]   count_d;
  logic [MEMORY_BITS:0]   len_d;
  logic [BITS-1:0]        sum_d;
  logic [MEMORY_BITS-1:0] addr_d;

  // The loader is ready exactly when it is busy, so a transfer is valid gated by busy.
  assign xfer    = in_valid & busy_q;
  assign count_d = count_q + (MEMORY_BITS+1)'(1);
  assign addr_d  = addr_q + MEMORY_BITS'(1);
  assign sum_d   = sum_q + in_data;
  // A length byte of zero encodes a completely full memory.
  assign len_d   = (in_data == '0) ? (MEMORY_BITS+1)'(MEMORY_SIZE)
                                   : (MEMORY_BITS+1)'(in_data);

  // Frame FSM: sequences LEN -> DATA -> CHECK and registers every output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      sum_q      <= '0;
      len_q      <= '0;
      count_q    <= '0;
    end else begin
      // Write strobe is a single-cycle pulse per payload transfer.
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_q <= ST_LEN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            count_q <= '0;
            addr_q  <= '0;
            sum_q   <= '0;
          end
        end
        ST_LEN: begin
          if (xfer) begin
            len_q   <= len_d;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= addr_q;
            mem_data_q <= in_data;
            addr_q     <= addr_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            if (count_d == len_q) begin
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (xfer) begin
            busy_q <= 1'b0;
            if (in_data == sum_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = busy_q;
  assign busy         = busy_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign done         = done_q;
  assign error        = error_q;
  assign loaded_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: a driver streams frames and queues the
// writes the frame implies; a negedge monitor pops and compares each write as it appears.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       busy;
  logic       done;
  logic       error;
  logic [8:0] loaded_count;

  program_loader #(.BITS(8), .MEMORY_BITS(8), .MEMORY_SIZE(256)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .error(error), .loaded_count(loaded_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frm[$];
  logic [7:0] tb_mem[256];
  int         cyc = 0;
  int         total = 0;
  int         passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  // Monitor: every write must match the oldest outstanding expectation, one cycle after its transfer.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", mem_addr, e.addr);
        check("write_data", mem_data, e.data);
        check("write_cycle", cyc, e.cyc);
      end
      tb_mem[mem_addr] = mem_data;
    end
    check("done_error_exclusive", done & error, 0);
  end

  // Reference model: payload length from the length byte, checksum is a plain modular sum.
  function automatic int payload_len();
    return (frm[0] == 8'h00) ? 256 : int'(frm[0]);
  endfunction

  function automatic bit frame_good();
    int n = payload_len();
    int s = 0;
    for (int i = 1; i <= n; i++) s += int'(frm[i]);
    return (s % 256) == int'(frm[n + 1]);
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_in_ready", in_ready, 1);
    check("start_done", done, 0);
    check("start_error", error, 0);
    check("start_count", loaded_count, 0);
  endtask

  // Streams frm[] with random bubbles; optionally pulses start while byte start_at is pending.
  task automatic send_frame(input int bubble_pct, input int start_at);
    int n = frm.size();
    int nd = payload_len();
    int idx = 0;
    int idle = 0;
    bit pulsed = 1'b0;
    while (idx < n) begin
      @(negedge clk);
      start = 1'b0;
      if (idx == start_at && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if ($urandom_range(99) < bubble_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = frm[idx];
        if (in_ready) begin
          if (idx >= 1 && idx <= nd) exp_q.push_back('{8'(idx - 1), frm[idx], cyc + 1});
          idx++;
          idle = 0;
        end
      end
      idle++;
      if (idle > 200) begin
        check("stream_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic check_result();
    bit good = frame_good();
    check("done", done, good);
    check("error", error, !good);
    check("loaded_count", loaded_count, payload_len());
    check("busy_after", busy, 0);
    check("in_ready_after", in_ready, 0);
    check("pending_writes", exp_q.size(), 0);
  endtask

  task automatic check_all_zero();
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_loaded_count", loaded_count, 0);
  endtask

  initial begin
    #1000000;
    check("global_timeout", 32'd1, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    int len;
    int s;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #2;
    check_all_zero();
    @(negedge clk);
    reset = 1'b0;

    // Basic good frame.
    do_start();
    frm = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_frame(0, -1);
    check_result();

    // in_valid while idle must not transfer, write or change status.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hAA;
    check("idle_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 1);
    check("idle_count", loaded_count, 3);

    // Bad checksum: writes still happen.
    do_start();
    frm = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
    send_frame(0, -1);
    check_result();

    // Full-memory frame with address wrap, then readback.
    do_start();
    frm = '{8'h00};
    for (int i = 0; i < 256; i++) frm.push_back(8'(i));
    frm.push_back(8'h80);
    send_frame(0, -1);
    check_result();
    for (int pc = 0; pc < 256; pc++) check("readback", tb_mem[pc], pc);

    // Bubbles plus a start pulse in the middle of DATA.
    do_start();
    frm = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_frame(50, 3);
    check_result();

    // Asynchronous reset after two payload transfers.
    do_start();
    frm = '{8'h03, 8'h11, 8'h22};
    send_frame(0, -1);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_count", loaded_count, 2);
    #1 reset = 1'b1;
    #1;
    check_all_zero();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    do_start();
    frm = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_frame(0, -1);
    check_result();

    // Random frames, good and bad checksums, random bubbles.
    for (int t = 0; t < 8; t++) begin
      do_start();
      len = $urandom_range(24, 1);
      frm = '{8'(len)};
      s = 0;
      for (int i = 0; i < len; i++) begin
        frm.push_back(8'($urandom));
        s += int'(frm[i + 1]);
      end
      if ($urandom_range(1) == 0) frm.push_back(8'(s));
      else frm.push_back(8'(s) ^ 8'($urandom_range(255, 1)));
      send_frame($urandom_range(60), -1);
      check_result();
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
